s2p_lane_arbiter: RTL
=====================

# s2p_lane_arbiter

Round-robin controller that shares one `serial_to_parallel` converter between `N_LANES` serial transmitters. It grants one lane per frame, muxes that lane's start/serial wires into the converter, and applies the lane's parity setting. Each received byte is tagged with its lane ID and buffered in a 2-entry output FIFO with a valid/ready handshake. It sits between the per-lane pin logic and the byte-stream consumer.

## Interface
- `N_LANES`, 4 — number of requesting lanes, 2..16.
- `START_TIMEOUT`, 15 — maximum cycles a granted lane may take to assert its start bit, 1..255.
- `LANE_W`, `$clog2(N_LANES)` — lane ID width; derived, not overridden.

Ports:
- `clock` in 1 — clock, rising edge.
- `reset_n` in 1 — reset, asynchronous, active-low; also drives the internal converter.
- `lane_req` in N_LANES — level request per lane.
- `lane_start` in N_LANES — per-lane start bit; honoured only for the granted lane.
- `lane_serial` in N_LANES — per-lane serial data.
- `lane_parity_en` in N_LANES — per-lane parity enable; latched at grant.
- `lane_gnt` out N_LANES — one-hot, one-cycle grant pulse.
- `out_valid` out 1 — FIFO head valid.
- `out_ready` in 1 — consumer accepts the head.
- `out_data` out 8 — received byte.
- `out_lane` out LANE_W — source lane of `out_data`.
- `out_parity_error` out 1 — parity error flag for `out_data`.
- `timeout` out 1 — one-cycle pulse when a granted lane fails to start.

## Operation
- FSM states: IDLE, GRANT, WAIT_START, RECEIVE.
- IDLE → GRANT when some `lane_req` bit is set and the FIFO holds fewer than 2 entries.
  - Selection is round-robin: the first requester at or after `rr_ptr+1`, wrapping modulo `N_LANES`.
  - The selected index is latched into `sel` and `lane_parity_en[sel]` into `par_q`.
- GRANT (1 cycle): `lane_gnt[sel]`=1. Set `rr_ptr`=`sel`. Go to WAIT_START and clear `to_cnt`.
- WAIT_START:
  - Converter `start_bit` = `lane_start[sel]` (combinational).
  - If `lane_start[sel]`=1 → RECEIVE.
  - Otherwise `to_cnt`++. When `to_cnt` reaches `START_TIMEOUT`, pulse `timeout` and go to IDLE. The lane forfeits its turn because `rr_ptr` is already advanced.
- RECEIVE:
  - Converter `start_bit`=0.
  - On converter `data_valid`, push {`sel`, data, parity_error} into the FIFO and go to IDLE.
- In all states:
  - Converter `serial_data` = `lane_serial[sel]`.
  - Converter `parity_enable` = `par_q`.
- `lane_start` from non-granted lanes is ignored. Dropping `lane_req` after grant has no effect on the frame in progress.
- FIFO: 2 entries. Push from RECEIVE; pop when `out_valid & out_ready`. Simultaneous push and pop on a full FIFO is legal and the count is unchanged. A push never meets a full FIFO, because grant requires a free slot and only one frame is in flight at a time.
- Reset: FSM=IDLE, `rr_ptr`=`N_LANES-1` (lane 0 wins first), FIFO empty, all outputs 0. Reset mid-frame discards the partial byte.

## Timing
- Request to grant: `lane_req` seen in IDLE at cycle T → `lane_gnt` at T+1. Earliest legal `lane_start` is T+2.
- Frame: start at cycle S carries bit 0, bits 0..7 occupy S..S+7, and parity (if enabled) occupies S+8.
- Converter `data_valid` arrives at S+8 without parity, S+9 with parity. FIFO entry visible (`out_valid`=1) at S+9 or S+10.
- Back-to-back: the next grant is possible the cycle after the push, giving a minimum frame-to-frame gap of 3 cycles.
- Timeout: `timeout` pulses in cycle T+2+`START_TIMEOUT` if no start is seen.
- `out_*` are registered FIFO outputs and hold stable while `out_valid & ~out_ready`.

## Configuration
- `S2P_ARB_STATS_EN` defined:
  - Adds output `err_count` (8 bits), a saturating count of pushed entries with parity_error=1.
  - Adds output `to_count` (8 bits), a saturating count of timeouts.
  - Both reset to 0 and saturate at 255.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Package `s2p_arb_pkg`:
  - `arb_state_t` enum (IDLE, GRANT, WAIT_START, RECEIVE).
  - `s2p_entry_t` struct {lane, data, parity_error}, parameterised by a max lane width of 4.
  - Constant `FIFO_DEPTH`=2.
- Sub-module `s2p_arb_fifo`: 2-entry register FIFO of `s2p_entry_t` with push, pop, full, empty and count.
- Instantiates `serial_to_parallel` internally.

## Test plan
- Single frame: lane 2 requests; start at S with bits LSB-first 0xA5 and parity off → `lane_gnt`=4'b0100, `out_data`=0xA5, `out_lane`=2, `out_parity_error`=0.
- Parity: lane 1 with parity on sends 0x3C plus parity bit 1 → `out_parity_error`=1. Resend with parity bit 0 → `out_parity_error`=0.
- Round-robin: all 4 lanes hold `lane_req` from reset → grant order 0,1,2,3,0. Each byte is tagged with the matching `out_lane`.
- Backpressure: `out_ready`=0 while 3 lanes request → two entries buffered and no third grant. Raising `out_ready` for 1 cycle → third grant follows; data order is preserved.
- Timeout: lane 3 granted and never starts → `timeout` pulses exactly `START_TIMEOUT`+1 cycles after `lane_gnt`, and lane 0 is granted next. With `S2P_ARB_STATS_EN`, `to_count`=1.
- Reset mid-frame: assert `reset_n`=0 at bit 4 → `out_valid`=0, FSM in IDLE. The next frame 0x5A from lane 0 is received correctly.

Source files
------------

// File: rtl/s2p_arb_pkg.sv
// s2p_arb_pkg: shared types and constants for the lane arbiter and its output FIFO.
package s2p_arb_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_LANE_W = 4;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECEIVE} arb_state_t;
  typedef struct packed {
    logic [MAX_LANE_W-1:0] lane;
    logic [7:0]            data;
    logic                  parity_error;
  } s2p_entry_t;
endpackage

// File: rtl/s2p_arb_fifo.sv
// s2p_arb_fifo: 2-entry register FIFO of tagged bytes; entry 0 is always the head.
module s2p_arb_fifo
  import s2p_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  s2p_entry_t din,
  output s2p_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  s2p_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push;
  always_comb begin
    do_pop = pop && count_q != 2'd0;
    do_push = push && (count_q != 2'(FIFO_DEPTH) || do_pop);
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    e0_d = do_pop ? e1_q : e0_q;
    e1_d = e1_q;
    if (do_push) begin
      if (count_d == 2'd1) e0_d = din;
      else e1_d = din;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign dout = e0_q;
  assign full = count_q == 2'(FIFO_DEPTH);
  assign empty = count_q == 2'd0;
  assign count = count_q;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: LSB-first 8-bit deserialiser with optional even-parity check bit.
module serial_to_parallel (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_bit,
  input  logic       serial_data,
  input  logic       parity_enable,
  output logic       data_valid,
  output logic [7:0] data_out,
  output logic       parity_error
);
  logic       busy_q, busy_d, valid_q, valid_d, perr_q, perr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  // start_bit qualifies bit 0 in the same cycle; cnt 8 marks the parity slot
  always_comb begin
    busy_d = busy_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    perr_d = perr_q;
    valid_d = 1'b0;
    if (!busy_q) begin
      if (start_bit) begin
        busy_d = 1'b1;
        cnt_d = 4'd1;
        sh_d[0] = serial_data;
      end
    end else if (cnt_q[3]) begin
      busy_d = 1'b0;
      valid_d = 1'b1;
      perr_d = ^sh_q ^ serial_data;
    end else begin
      sh_d[cnt_q[2:0]] = serial_data;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7 && !parity_enable) begin
        busy_d = 1'b0;
        valid_d = 1'b1;
        perr_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
    end
  end
  assign data_valid = valid_q;
  assign data_out = sh_q;
  assign parity_error = perr_q;
endmodule

// File: rtl/s2p_lane_arbiter.sv
// s2p_lane_arbiter: round-robin share of one serial_to_parallel between N_LANES serial lanes.
// Define S2P_ARB_STATS_EN to add saturating err_count / to_count outputs.
module s2p_lane_arbiter
  import s2p_arb_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int START_TIMEOUT = 15,
  localparam int LANE_W = $clog2(N_LANES)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_LANES-1:0] lane_req,
  input  logic [N_LANES-1:0] lane_start,
  input  logic [N_LANES-1:0] lane_serial,
  input  logic [N_LANES-1:0] lane_parity_en,
  output logic [N_LANES-1:0] lane_gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [LANE_W-1:0]  out_lane,
  output logic               out_parity_error,
`ifdef S2P_ARB_STATS_EN
  output logic [7:0]         err_count,
  output logic [7:0]         to_count,
`endif
  output logic               timeout
);
  localparam logic [LANE_W:0] NL = (LANE_W+1)'(N_LANES);
  localparam logic [7:0] TO_LIM = 8'(START_TIMEOUT);
  arb_state_t state_q, state_d;
  logic [LANE_W-1:0] sel_q, sel_d, rr_q, rr_d, off, pick;
  logic [N_LANES-1:0] gnt_q, gnt_d, rot;
  logic [2*N_LANES-1:0] req2;
  logic [LANE_W:0] sum, diff;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic par_q, par_d, timeout_q, timeout_d;
  logic start_bit, push, cv_valid, cv_perr, fifo_full, fifo_empty;
  logic [7:0] cv_data;
  logic [1:0] fifo_count_unused;
  s2p_entry_t push_entry, head;
  // rotate so bit 0 is lane rr+1, take the lowest requester, then rotate back
  always_comb begin
    req2 = {lane_req, lane_req} >> ({1'b0, rr_q} + (LANE_W+1)'(1));
    rot = req2[N_LANES-1:0];
    off = '0;
    for (int i = N_LANES - 1; i >= 0; i--) if (rot[i]) off = LANE_W'(i);
    sum = {1'b0, rr_q} + {1'b0, off} + (LANE_W+1)'(1);
    diff = sum - NL;
    pick = (sum >= NL) ? diff[LANE_W-1:0] : sum[LANE_W-1:0];
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_d = rr_q;
    par_d = par_q;
    to_cnt_d = to_cnt_q;
    gnt_d = '0;
    timeout_d = 1'b0;
    start_bit = 1'b0;
    push = 1'b0;
    case (state_q)
      IDLE: if (|lane_req && !fifo_full) begin
        state_d = GRANT;
        sel_d = pick;
        par_d = lane_parity_en[pick];
        gnt_d = N_LANES'(1) << pick;
      end
      GRANT: begin
        state_d = WAIT_START;
        rr_d = sel_q;
        to_cnt_d = '0;
      end
      WAIT_START: begin
        start_bit = lane_start[sel_q];
        to_cnt_d = to_cnt_q + 8'd1;
        if (start_bit) state_d = RECEIVE;
        else if (to_cnt_d == TO_LIM) begin
          timeout_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: if (cv_valid) begin
        push = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= LANE_W'(N_LANES - 1);
      par_q <= 1'b0;
      to_cnt_q <= '0;
      gnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      par_q <= par_d;
      to_cnt_q <= to_cnt_d;
      gnt_q <= gnt_d;
      timeout_q <= timeout_d;
    end
  end
  serial_to_parallel u_s2p (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_bit    (start_bit),
    .serial_data  (lane_serial[sel_q]),
    .parity_enable(par_q),
    .data_valid   (cv_valid),
    .data_out     (cv_data),
    .parity_error (cv_perr)
  );
  assign push_entry = {MAX_LANE_W'(sel_q), cv_data, cv_perr};
  s2p_arb_fifo u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (out_valid && out_ready),
    .din    (push_entry),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count_unused)
  );
  assign lane_gnt = gnt_q;
  assign timeout = timeout_q;
  assign out_valid = !fifo_empty;
  assign out_data = head.data;
  assign out_lane = head.lane[LANE_W-1:0];
  assign out_parity_error = head.parity_error;
`ifdef S2P_ARB_STATS_EN
  logic [7:0] err_q, err_d, toc_q, toc_d;
  always_comb begin
    err_d = (push && cv_perr && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    toc_d = (timeout_d && toc_q != 8'hFF) ? toc_q + 8'd1 : toc_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
      toc_q <= '0;
    end else begin
      err_q <= err_d;
      toc_q <= toc_d;
    end
  end
  assign err_count = err_q;
  assign to_count = toc_q;
`endif
endmodule
